// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory ready handshake with timeout, sticky illegal/timeout trap.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 2,
  parameter int IMMSEL_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int ENABLE_JAL  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic [1:0]          mem_to_reg,
  output logic [IMMSEL_W-1:0] imm_sel,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [IMMSEL_W-1:0] IMM_I = IMMSEL_W'(0);
  localparam logic [IMMSEL_W-1:0] IMM_S = IMMSEL_W'(1);
  localparam logic [IMMSEL_W-1:0] IMM_B = IMMSEL_W'(2);
  localparam logic [IMMSEL_W-1:0] IMM_J = IMMSEL_W'(3);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_FNI  = ALUOP_W'(3);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [6:0]    op_q;
  logic          illegal_q;
  logic          timeout_q;
  logic          op_legal;

  assign state   = st;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  // Legality of the opcode currently presented by the instruction register
  always_comb begin
    op_legal = (opcode inside {OP_R, OP_LOAD, OP_STORE,
                               OP_BRANCH, OP_IALU}) ||
               ((ENABLE_JAL != 0) && (opcode == OP_JAL));
  end

  // State sequencing, wait counter, opcode latch and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_FETCH;
      cnt       <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            cnt <= '0;
            st  <= S_DECODE;
          end else if (cnt == TO_V) begin
            st        <= S_TRAP;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          cnt  <= '0;
          if (op_legal) begin
            st <= S_EXEC;
          end else begin
            st        <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          cnt <= '0;
          if (op_q == OP_LOAD || op_q == OP_STORE)
            st <= S_MEM;
          else if (op_q == OP_BRANCH)
            st <= S_FETCH;
          else
            st <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            cnt <= '0;
            st  <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
          end else if (cnt == TO_V) begin
            st        <= S_TRAP;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WB: begin
          cnt <= '0;
          st  <= S_FETCH;
        end
        S_TRAP: begin
          st <= S_TRAP;
        end
        default: begin
          cnt <= '0;
          st  <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath enables from current state and latched opcode
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 2'b00;
    imm_sel    = IMM_I;
    alu_op     = ALU_ADD;
    case (st)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op = ALU_FN;
          end
          OP_IALU: begin
            alu_src = 1'b1;
            imm_sel = IMM_I;
            alu_op  = ALU_FNI;
          end
          OP_LOAD: begin
            alu_src = 1'b1;
            imm_sel = IMM_I;
          end
          OP_STORE: begin
            alu_src = 1'b1;
            imm_sel = IMM_S;
          end
          OP_BRANCH: begin
            imm_sel  = IMM_B;
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = branch_taken;
          end
          OP_JAL: begin
            imm_sel  = IMM_J;
            pc_src   = 1'b1;
            pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_LOAD)
          mem_to_reg = 2'b01;
        else if (op_q == OP_JAL)
          mem_to_reg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected traces
// built from instruction class, checked cycle by cycle.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;

  logic       pcw [3];
  logic       pcs [3];
  logic       irw [3];
  logic       rw  [3];
  logic       mr  [3];
  logic       mw  [3];
  logic       as  [3];
  logic [1:0] m2r [3];
  logic [2:0] imm [3];
  logic [1:0] aop [3];
  logic [2:0] st  [3];
  logic       ill [3];
  logic       to  [3];

  logic [18:0] obs [3];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic        bt;
    logic [18:0] exp;
  } cyc_t;

  cyc_t q[$];

  multicycle_control_unit u0 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pcw[0]), .pc_src(pcs[0]), .ir_write(irw[0]),
    .reg_write(rw[0]), .mem_read(mr[0]), .mem_write(mw[0]),
    .alu_src(as[0]), .mem_to_reg(m2r[0]), .imm_sel(imm[0]),
    .alu_op(aop[0]), .state(st[0]), .illegal(ill[0]),
    .timeout(to[0])
  );

  multicycle_control_unit #(.ENABLE_JAL(0)) u1 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pcw[1]), .pc_src(pcs[1]), .ir_write(irw[1]),
    .reg_write(rw[1]), .mem_read(mr[1]), .mem_write(mw[1]),
    .alu_src(as[1]), .mem_to_reg(m2r[1]), .imm_sel(imm[1]),
    .alu_op(aop[1]), .state(st[1]), .illegal(ill[1]),
    .timeout(to[1])
  );

  multicycle_control_unit #(.MEM_TIMEOUT(3)) u2 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pcw[2]), .pc_src(pcs[2]), .ir_write(irw[2]),
    .reg_write(rw[2]), .mem_read(mr[2]), .mem_write(mw[2]),
    .alu_src(as[2]), .mem_to_reg(m2r[2]), .imm_sel(imm[2]),
    .alu_op(aop[2]), .state(st[2]), .illegal(ill[2]),
    .timeout(to[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {st[g], pcw[g], pcs[g], irw[g], rw[g],
                     mr[g], mw[g], as[g], m2r[g], imm[g],
                     aop[g], ill[g], to[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(
    logic [2:0] s, logic p_w, logic p_s, logic i_w,
    logic r_w, logic m_r, logic m_w, logic a_s,
    logic [1:0] mtr, logic [2:0] im, logic [1:0] ao);
    return {s, p_w, p_s, i_w, r_w, m_r, m_w, a_s, mtr, im, ao};
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom());
  endfunction

  function automatic logic rb();
    return 1'($urandom());
  endfunction

  task automatic push(logic [6:0] op, logic rdy, logic bt,
                      logic [16:0] e, logic il, logic tf);
    cyc_t c;
    c.op  = op;
    c.rdy = rdy;
    c.bt  = bt;
    c.exp = {e, il, tf};
    q.push_back(c);
  endtask

  // expected cycles of one instruction from its class and wait counts
  task automatic build(logic [6:0] op, int fw, int mwt, logic bt);
    logic [16:0] fwait, fdone, dec, wb0, memld, memst;
    fwait = mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0);
    fdone = mk(3'd0,1,0,1,0,1,0,0,2'd0,3'd0,2'd0);
    dec   = mk(3'd1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0);
    wb0   = mk(3'd4,0,0,0,1,0,0,0,2'd0,3'd0,2'd0);
    memld = mk(3'd3,0,0,0,0,1,0,0,2'd0,3'd0,2'd0);
    memst = mk(3'd3,0,0,0,0,0,1,0,2'd0,3'd0,2'd0);
    repeat (fw) push(rop(), 1'b0, rb(), fwait, 0, 0);
    push(rop(), 1'b1, rb(), fdone, 0, 0);
    push(op, rb(), rb(), dec, 0, 0);
    case (op)
      OP_R: begin
        push(rop(), rb(), rb(),
             mk(3'd2,0,0,0,0,0,0,0,2'd0,3'd0,2'd2), 0, 0);
        push(rop(), rb(), rb(), wb0, 0, 0);
      end
      OP_I: begin
        push(rop(), rb(), rb(),
             mk(3'd2,0,0,0,0,0,0,1,2'd0,3'd0,2'd3), 0, 0);
        push(rop(), rb(), rb(), wb0, 0, 0);
      end
      OP_LD: begin
        push(rop(), rb(), rb(),
             mk(3'd2,0,0,0,0,0,0,1,2'd0,3'd0,2'd0), 0, 0);
        repeat (mwt) push(rop(), 1'b0, rb(), memld, 0, 0);
        push(rop(), 1'b1, rb(), memld, 0, 0);
        push(rop(), rb(), rb(),
             mk(3'd4,0,0,0,1,0,0,0,2'd1,3'd0,2'd0), 0, 0);
      end
      OP_ST: begin
        push(rop(), rb(), rb(),
             mk(3'd2,0,0,0,0,0,0,1,2'd0,3'd1,2'd0), 0, 0);
        repeat (mwt) push(rop(), 1'b0, rb(), memst, 0, 0);
        push(rop(), 1'b1, rb(), memst, 0, 0);
      end
      OP_BR: begin
        push(rop(), rb(), bt,
             mk(3'd2,bt,1,0,0,0,0,0,2'd0,3'd2,2'd1), 0, 0);
      end
      default: begin
        push(rop(), rb(), rb(),
             mk(3'd2,1,1,0,0,0,0,0,2'd0,3'd3,2'd0), 0, 0);
        push(rop(), rb(), rb(),
             mk(3'd4,0,0,0,1,0,0,0,2'd2,3'd0,2'd0), 0, 0);
      end
    endcase
  endtask

  task automatic run_q(string nm, int w);
    cyc_t c;
    int k;
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode       = c.op;
      mem_ready    = c.rdy;
      branch_taken = c.bt;
      #2;
      total++;
      if (obs[w] !== c.exp)
        $display("FAIL %s cyc%0d dut%0d got %b want %b",
                 nm, k, w, obs[w], c.exp);
      else
        passed++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    mem_ready    = rb();
    opcode       = rop();
    branch_taken = rb();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push(rop(), 1'b0, rb(),
         mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    run_q("reset_fetch", 0);
  endtask

  task automatic test_r_type();
    do_reset();
    build(OP_R, 0, 0, 1'b0);
    push(rop(), 1'b0, rb(),
         mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    run_q("r_type", 0);
  endtask

  task automatic test_load_wait();
    do_reset();
    build(OP_LD, 0, 3, 1'b0);
    build(OP_LD, 15, 15, 1'b0);
    build(OP_ST, 2, 15, 1'b0);
    run_q("load_wait", 0);
  endtask

  task automatic test_branch();
    do_reset();
    build(OP_BR, 0, 0, 1'b1);
    build(OP_BR, 0, 0, 1'b0);
    build(OP_JAL, 0, 0, 1'b0);
    build(OP_I, 1, 0, 1'b0);
    run_q("branch_jal", 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops = '{OP_R, OP_LD, OP_ST, OP_BR, OP_I, OP_JAL};
    do_reset();
    for (int i = 0; i < 60; i++)
      build(ops[$urandom_range(0, 5)], $urandom_range(0, 15),
            $urandom_range(0, 15), rb());
    run_q("random", 0);
  endtask

  task automatic test_illegal();
    logic [16:0] trap;
    trap = mk(3'd5,0,0,0,0,0,0,0,2'd0,3'd0,2'd0);
    do_reset();
    push(rop(), 1'b1, rb(),
         mk(3'd0,1,0,1,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(OP_BAD, rb(), rb(),
         mk(3'd1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0), 0, 0);
    repeat (6) push(rop(), rb(), rb(), trap, 1, 0);
    run_q("illegal_trap", 0);
    do_reset();
    push(rop(), 1'b1, rb(),
         mk(3'd0,1,0,1,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(OP_JAL, rb(), rb(),
         mk(3'd1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0), 0, 0);
    repeat (4) push(rop(), rb(), rb(), trap, 1, 0);
    run_q("jal_disabled", 1);
    do_reset();
    push(rop(), 1'b0, rb(),
         mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    run_q("flags_cleared", 1);
  endtask

  task automatic test_timeout();
    logic [16:0] fwait, trap;
    fwait = mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0);
    trap  = mk(3'd5,0,0,0,0,0,0,0,2'd0,3'd0,2'd0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      opcode       = rop();
      branch_taken = rb();
      mem_ready    = 1'b0;
      #2;
      total++;
      if (obs[2] !== ((i < 4) ? {fwait, 2'b00} : {trap, 2'b01}))
        $display("FAIL timeout_fetch3 cyc%0d got %b", i, obs[2]);
      else
        passed++;
      total++;
      if (obs[0] !== ((i < 16) ? {fwait, 2'b00} : {trap, 2'b01}))
        $display("FAIL timeout_fetch15 cyc%0d got %b", i, obs[0]);
      else
        passed++;
      @(negedge clk);
    end
    do_reset();
    push(rop(), 1'b1, rb(),
         mk(3'd0,1,0,1,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(OP_LD, rb(), rb(),
         mk(3'd1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(rop(), rb(), rb(),
         mk(3'd2,0,0,0,0,0,0,1,2'd0,3'd0,2'd0), 0, 0);
    repeat (16) push(rop(), 1'b0, rb(),
         mk(3'd3,0,0,0,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    repeat (3) push(rop(), rb(), rb(), trap, 0, 1);
    run_q("timeout_mem", 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(rop(), 1'b1, rb(),
         mk(3'd0,1,0,1,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(OP_ST, rb(), rb(),
         mk(3'd1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0), 0, 0);
    push(rop(), rb(), rb(),
         mk(3'd2,0,0,0,0,0,0,1,2'd0,3'd1,2'd0), 0, 0);
    repeat (2) push(rop(), 1'b0, rb(),
         mk(3'd3,0,0,0,0,0,1,0,2'd0,3'd0,2'd0), 0, 0);
    run_q("store_pre", 0);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push(rop(), 1'b0, rb(),
         mk(3'd0,0,0,0,0,1,0,0,2'd0,3'd0,2'd0), 0, 0);
    run_q("reset_mid_store", 0);
  endtask

  initial begin
    reset        = 1'b1;
    opcode       = '0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    @(negedge clk);
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
